// File: rtl/uart_frame_assembler.sv
// Collects cmd, address, data and an optional checksum byte from the UART receiver
// into one frame and hands it downstream through a valid/ready handshake.
module uart_frame_assembler #(
  parameter int ADDR_BYTES     = 1,
  parameter int DATA_BYTES     = 2,
  parameter int CHECKSUM_EN    = 1,
  parameter int DATA_MSB_FIRST = 0,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_data,
  output logic                    frm_valid,
  input  logic                    frm_ready,
  output logic [7:0]              frm_cmd,
  output logic [8*ADDR_BYTES-1:0] frm_addr,
  output logic [8*DATA_BYTES-1:0] frm_data,
  output logic                    busy,
  output logic                    err_timeout,
  output logic                    err_checksum,
  output logic                    err_overrun
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {S_CMD, S_ADDR, S_DATA, S_CSUM, S_HOLD} state_t;

  state_t                  state;
  logic [1:0]              bcnt;
  logic [7:0]              sum;
  logic [7:0]              cmd_sh;
  logic [8*ADDR_BYTES-1:0] addr_sh;
  logic [8*ADDR_BYTES-1:0] addr_nxt;
  logic [8*DATA_BYTES-1:0] data_sh;
  logic [8*DATA_BYTES-1:0] data_nxt;
  logic [TW-1:0]           tcnt;
  logic [TW-1:0]           tcnt_inc;
  logic                    to_hit;
  logic                    last_addr;
  logic                    last_data;
  logic                    csum_ok;

  // Shadow registers with the incoming byte merged into its slot.
  always_comb begin
    addr_nxt = addr_sh;
    data_nxt = data_sh;
    for (int i = 0; i < ADDR_BYTES; i++)
      if (32'(bcnt) == ADDR_BYTES - 1 - i) addr_nxt[8*i +: 8] = rx_data;
    for (int i = 0; i < DATA_BYTES; i++)
      if (32'(bcnt) == ((DATA_MSB_FIRST != 0) ? (DATA_BYTES - 1 - i) : i))
        data_nxt[8*i +: 8] = rx_data;
    last_addr = (32'(bcnt) == ADDR_BYTES - 1);
    last_data = (32'(bcnt) == DATA_BYTES - 1);
    csum_ok   = (8'(sum + rx_data) == 8'd0);
    tcnt_inc  = tcnt + TW'(1);
    // The timeout fires on the idle cycle in which the counter would reach TLAST.
    to_hit    = (TIMEOUT_CYCLES != 0) && ((TIMEOUT_CYCLES == 1) || (tcnt_inc == TLAST));
  end

  assign busy = (state != S_CMD);

  // Handshake: frm_valid rises with the frame and holds it unchanged until the
  // cycle where frm_valid && frm_ready, which is the single transfer cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_CMD;
      bcnt         <= '0;
      sum          <= '0;
      tcnt         <= '0;
      cmd_sh       <= '0;
      addr_sh      <= '0;
      data_sh      <= '0;
      frm_valid    <= 1'b0;
      frm_cmd      <= '0;
      frm_addr     <= '0;
      frm_data     <= '0;
      err_timeout  <= 1'b0;
      err_checksum <= 1'b0;
      err_overrun  <= 1'b0;
    end else begin
      err_timeout  <= 1'b0;
      err_checksum <= 1'b0;
      err_overrun  <= 1'b0;
      case (state)
        S_CMD: begin
          if (rx_valid) begin
            cmd_sh <= rx_data;
            sum    <= rx_data;
            bcnt   <= '0;
            tcnt   <= '0;
            state  <= S_ADDR;
          end
        end
        S_ADDR, S_DATA, S_CSUM: begin
          if (rx_valid) begin
            tcnt <= '0;
            sum  <= sum + rx_data;
            if (state == S_ADDR) begin
              addr_sh <= addr_nxt;
              if (last_addr) begin
                bcnt  <= '0;
                state <= S_DATA;
              end else begin
                bcnt <= bcnt + 2'd1;
              end
            end else if (state == S_DATA) begin
              data_sh <= data_nxt;
              if (!last_data) begin
                bcnt <= bcnt + 2'd1;
              end else begin
                bcnt <= '0;
                if (CHECKSUM_EN != 0) begin
                  state <= S_CSUM;
                end else begin
                  frm_cmd   <= cmd_sh;
                  frm_addr  <= addr_sh;
                  frm_data  <= data_nxt;
                  frm_valid <= 1'b1;
                  state     <= S_HOLD;
                end
              end
            end else if (csum_ok) begin
              frm_cmd   <= cmd_sh;
              frm_addr  <= addr_sh;
              frm_data  <= data_sh;
              frm_valid <= 1'b1;
              state     <= S_HOLD;
            end else begin
              err_checksum <= 1'b1;
              sum          <= '0;
              state        <= S_CMD;
            end
          end else if (to_hit) begin
            err_timeout <= 1'b1;
            bcnt        <= '0;
            tcnt        <= '0;
            sum         <= '0;
            state       <= S_CMD;
          end else begin
            tcnt <= tcnt_inc;
          end
        end
        S_HOLD: begin
          if (frm_ready) begin
            frm_valid <= 1'b0;
            // A byte arriving with the transfer is the next command byte.
            if (rx_valid) begin
              cmd_sh <= rx_data;
              sum    <= rx_data;
              bcnt   <= '0;
              tcnt   <= '0;
              state  <= S_ADDR;
            end else begin
              sum   <= '0;
              state <= S_CMD;
            end
          end else if (rx_valid) begin
            err_overrun <= 1'b1;
          end
        end
        default: state <= S_CMD;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_assembler.sv
// Directed bench: config A (1 addr, 2 data, checksum, 16-cycle timeout) and
// config B (2 addr, 4 data, no checksum, data MSB first).
module tb_uart_frame_assembler;

  logic        clk;
  logic        reset;
  logic        rx_valid_a, rx_valid_b;
  logic [7:0]  rx_data_a, rx_data_b;
  logic        frm_ready_a, frm_ready_b;
  logic        frm_valid_a, frm_valid_b;
  logic [7:0]  frm_cmd_a, frm_cmd_b;
  logic [7:0]  frm_addr_a;
  logic [15:0] frm_addr_b;
  logic [15:0] frm_data_a;
  logic [31:0] frm_data_b;
  logic        busy_a, busy_b;
  logic        err_timeout_a, err_checksum_a, err_overrun_a;
  logic        err_timeout_b, err_checksum_b, err_overrun_b;

  int n_checks = 0;
  int n_pass   = 0;
  int xfers_a = 0, xfers_b = 0;
  int touts_a = 0, csums_a = 0, ovrs_a = 0, mutex_bad = 0;
  logic [31:0] exp_q[$];
  logic [55:0] exp_b_q[$];

  uart_frame_assembler #(
    .ADDR_BYTES(1), .DATA_BYTES(2), .CHECKSUM_EN(1), .DATA_MSB_FIRST(0), .TIMEOUT_CYCLES(16)
  ) dut_a (
    .clk(clk), .reset(reset), .rx_valid(rx_valid_a), .rx_data(rx_data_a),
    .frm_valid(frm_valid_a), .frm_ready(frm_ready_a), .frm_cmd(frm_cmd_a),
    .frm_addr(frm_addr_a), .frm_data(frm_data_a), .busy(busy_a),
    .err_timeout(err_timeout_a), .err_checksum(err_checksum_a), .err_overrun(err_overrun_a)
  );

  uart_frame_assembler #(
    .ADDR_BYTES(2), .DATA_BYTES(4), .CHECKSUM_EN(0), .DATA_MSB_FIRST(1), .TIMEOUT_CYCLES(100000)
  ) dut_b (
    .clk(clk), .reset(reset), .rx_valid(rx_valid_b), .rx_data(rx_data_b),
    .frm_valid(frm_valid_b), .frm_ready(frm_ready_b), .frm_cmd(frm_cmd_b),
    .frm_addr(frm_addr_b), .frm_data(frm_data_b), .busy(busy_b),
    .err_timeout(err_timeout_b), .err_checksum(err_checksum_b), .err_overrun(err_overrun_b)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Drivers: called on a negedge, return on a negedge
  task automatic send_a(input logic [7:0] b, input int gap);
    rx_valid_a = 1'b1;
    rx_data_a  = b;
    @(negedge clk);
    rx_valid_a = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_b(input logic [7:0] b, input int gap);
    rx_valid_b = 1'b1;
    rx_data_b  = b;
    @(negedge clk);
    rx_valid_b = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame_a(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d0,
                              input logic [7:0] d1, input logic [7:0] cs, input int gap);
    send_a(c, gap);
    send_a(a, gap);
    send_a(d0, gap);
    send_a(d1, gap);
    send_a(cs, 0);
  endtask

  // Scoreboard and event counters, sampled mid-cycle after the drivers settle
  always @(negedge clk) begin
    #2;
    if (frm_valid_a && frm_ready_a) begin
      xfers_a++;
      if (exp_q.size() == 0) check("unexpected_frame_a", {frm_cmd_a, frm_addr_a, frm_data_a}, 32'hx);
      else check("frame_a", {frm_cmd_a, frm_addr_a, frm_data_a}, exp_q.pop_front());
    end
    if (frm_valid_b && frm_ready_b) begin
      xfers_b++;
      if (exp_b_q.size() == 0) check("unexpected_frame_b", {frm_cmd_b, frm_addr_b, frm_data_b}, 56'hx);
      else check("frame_b", {frm_cmd_b, frm_addr_b, frm_data_b}, exp_b_q.pop_front());
    end
    if (err_timeout_a)  touts_a++;
    if (err_checksum_a) csums_a++;
    if (err_overrun_a)  ovrs_a++;
    if ($countones({err_timeout_a, err_checksum_a, err_overrun_a}) > 1) mutex_bad++;
  end

  initial begin
    reset = 1'b1;
    rx_valid_a = 1'b0; rx_data_a = 8'h00; frm_ready_a = 1'b1;
    rx_valid_b = 1'b0; rx_data_b = 8'h00; frm_ready_b = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_valid_a", frm_valid_a, 1'b0);
    check("reset_busy_a", busy_a, 1'b0);
    check("reset_frame_a", {frm_cmd_a, frm_addr_a, frm_data_a}, 32'h0);
    check("reset_errs_a", {err_timeout_a, err_checksum_a, err_overrun_a}, 3'b000);
    check("reset_b", {frm_valid_b, busy_b, frm_addr_b, frm_data_b}, 50'h0);

    // Default frame with spacing
    exp_q.push_back(32'h02_10_1234);
    send_frame_a(8'h02, 8'h10, 8'h34, 8'h12, 8'hA8, 2);
    check("t1_valid", frm_valid_a, 1'b1);
    check("t1_cmd", frm_cmd_a, 8'h02);
    check("t1_addr", frm_addr_a, 8'h10);
    check("t1_data", frm_data_a, 16'h1234);
    @(negedge clk);
    check("t1_valid_drop", frm_valid_a, 1'b0);

    // Bad checksum, then a good frame
    send_frame_a(8'h02, 8'h10, 8'h34, 8'h12, 8'hA7, 1);
    check("csum_err_pulse", err_checksum_a, 1'b1);
    check("csum_no_valid", frm_valid_a, 1'b0);
    @(negedge clk);
    check("csum_err_width", err_checksum_a, 1'b0);
    exp_q.push_back(32'h02_10_1234);
    send_frame_a(8'h02, 8'h10, 8'h34, 8'h12, 8'hA8, 1);
    check("csum_recover_valid", frm_valid_a, 1'b1);

    // Back-to-back frames at one byte per clock
    repeat (2) @(negedge clk);
    exp_q.push_back(32'h02_10_1234);
    exp_q.push_back(32'h03_20_7856);
    send_frame_a(8'h02, 8'h10, 8'h34, 8'h12, 8'hA8, 0);
    send_frame_a(8'h03, 8'h20, 8'h56, 8'h78, 8'h0F, 0);
    check("b2b_valid", frm_valid_a, 1'b1);
    check("b2b_data", frm_data_a, 16'h7856);

    // Timeout after 0x10 with silence
    repeat (2) @(negedge clk);
    send_a(8'h02, 1);
    send_a(8'h10, 0);
    repeat (14) @(negedge clk);
    check("tout_early", err_timeout_a, 1'b0);
    check("tout_busy_before", busy_a, 1'b1);
    @(negedge clk);
    check("tout_pulse", err_timeout_a, 1'b1);
    @(negedge clk);
    check("tout_width", err_timeout_a, 1'b0);
    check("tout_busy_after", busy_a, 1'b0);
    exp_q.push_back(32'h02_10_1234);
    send_frame_a(8'h02, 8'h10, 8'h34, 8'h12, 8'hA8, 1);
    check("tout_recover_valid", frm_valid_a, 1'b1);

    // A byte in the timeout cycle is accepted
    repeat (2) @(negedge clk);
    send_a(8'h02, 1);
    send_a(8'h10, 0);
    repeat (14) @(negedge clk);
    send_a(8'h34, 0);
    check("tout_edge_no_err", err_timeout_a, 1'b0);
    check("tout_edge_busy", busy_a, 1'b1);
    exp_q.push_back(32'h02_10_1234);
    send_a(8'h12, 1);
    send_a(8'hA8, 0);
    check("tout_edge_valid", frm_valid_a, 1'b1);

    // Overrun while the frame is held
    @(negedge clk);
    frm_ready_a = 1'b0;
    exp_q.push_back(32'h07_01_BEEF);
    send_frame_a(8'h07, 8'h01, 8'hEF, 8'hBE, 8'h4B, 1);
    check("ovr_valid", frm_valid_a, 1'b1);
    send_a(8'h55, 1);
    send_a(8'h66, 0);
    check("ovr_pulse", err_overrun_a, 1'b1);
    check("ovr_held_valid", frm_valid_a, 1'b1);
    check("ovr_held_frame", {frm_cmd_a, frm_addr_a, frm_data_a}, 32'h07_01_BEEF);
    @(negedge clk);
    frm_ready_a = 1'b1;
    @(negedge clk);
    check("ovr_released", frm_valid_a, 1'b0);

    // Reset after the 3rd byte of a frame
    send_a(8'h02, 1);
    send_a(8'h10, 1);
    send_a(8'h34, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_outputs", {frm_valid_a, busy_a, err_timeout_a, err_checksum_a, err_overrun_a}, 5'b0);
    check("midrst_frame", {frm_cmd_a, frm_addr_a, frm_data_a}, 32'h0);
    exp_q.push_back(32'h03_20_7856);
    send_frame_a(8'h03, 8'h20, 8'h56, 8'h78, 8'h0F, 1);
    check("midrst_fresh_valid", frm_valid_a, 1'b1);
    check("midrst_fresh_frame", {frm_cmd_a, frm_addr_a, frm_data_a}, 32'h03_20_7856);

    // Config B: wide fields, no checksum, data MSB first
    @(negedge clk);
    exp_b_q.push_back(56'h05_ABCD_11223344);
    send_b(8'h05, 1);
    send_b(8'hAB, 1);
    send_b(8'hCD, 1);
    send_b(8'h11, 1);
    send_b(8'h22, 1);
    send_b(8'h33, 1);
    send_b(8'h44, 0);
    check("b_valid", frm_valid_b, 1'b1);
    check("b_cmd", frm_cmd_b, 8'h05);
    check("b_addr", frm_addr_b, 16'hABCD);
    check("b_data", frm_data_b, 32'h11223344);
    check("b_no_errs", {err_timeout_b, err_checksum_b, err_overrun_b}, 3'b000);
    @(negedge clk);
    check("b_valid_drop", frm_valid_b, 1'b0);

    repeat (4) @(negedge clk);
    check("xfers_a", xfers_a, 8);
    check("xfers_b", xfers_b, 1);
    check("timeouts_a", touts_a, 1);
    check("checksum_errs_a", csums_a, 1);
    check("overruns_a", ovrs_a, 2);
    check("err_mutex", mutex_bad, 0);
    check("exp_q_empty", exp_q.size(), 0);
    check("exp_b_q_empty", exp_b_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_frame_assembler.md
# uart_frame_assembler

Parametrised command-frame assembler between the byte-level UART receiver and the SPI master. It collects one command byte, ADDR_BYTES address bytes, DATA_BYTES data bytes and an optional checksum byte into a complete frame. It then presents the frame to the downstream consumer with a valid/ready handshake. It adds inter-byte timeout, checksum checking and overrun detection.

## Interface
- ADDR_BYTES, 1, number of address bytes per frame (1..4)
- DATA_BYTES, 2, number of data bytes per frame (1..4)
- CHECKSUM_EN, 1, 1 = a trailing checksum byte is expected and checked; 0 = no checksum byte
- DATA_MSB_FIRST, 0, 0 = first received data byte lands in frm_data[7:0]; 1 = first received data byte lands in the top byte
- TIMEOUT_CYCLES, 100000, maximum idle clk cycles between bytes inside a frame; 0 disables the timeout
- clk  in  1  system clock, single clock domain
- reset  in  1  synchronous, active-high reset
- rx_valid  in  1  one-cycle strobe from the UART receiver: rx_data is valid
- rx_data  in  8  received byte
- frm_valid  out  1  a complete frame is held on frm_cmd, frm_addr and frm_data
- frm_ready  in  1  the consumer accepts the frame
- frm_cmd  out  8  command byte
- frm_addr  out  8*ADDR_BYTES  address; the first received address byte is the most significant byte
- frm_data  out  8*DATA_BYTES  data; byte order set by DATA_MSB_FIRST
- busy  out  1  high in every state except S_CMD
- err_timeout  out  1  one-cycle pulse: the frame was aborted by a timeout
- err_checksum  out  1  one-cycle pulse: the frame was dropped on a checksum mismatch
- err_overrun  out  1  one-cycle pulse: a byte was dropped while a frame was held

## Operation
- States:
  - S_CMD: wait for the command byte.
  - S_ADDR, S_DATA: collect address and data bytes.
  - S_CSUM: wait for the checksum byte; skipped when CHECKSUM_EN=0.
  - S_HOLD: frame presented downstream.
- A byte counter of width clog2(4) indexes bytes within S_ADDR and S_DATA.
- On each rx_valid in S_ADDR or S_DATA, the byte is written into its slot and the counter increments. The state advances after the last byte and the counter clears.
- Running checksum: an 8-bit sum, modulo 256, of every frame byte. It clears on entry to S_CMD.
- Checksum rule: the frame is good when (sum + checksum byte) mod 256 == 0.
  - Good: go to S_HOLD.
  - Bad: pulse err_checksum, return to S_CMD, frm_valid stays 0.
- With CHECKSUM_EN=0, the last data byte goes directly to S_HOLD.
- Frame outputs change only on the transition into S_HOLD. They are stable for as long as frm_valid=1.
- S_HOLD behaviour:
  - An rx_valid while frm_ready=0 drops the byte and pulses err_overrun.
  - An rx_valid in the same cycle as frm_ready=1 is taken as the next command byte; the next state is S_ADDR.
- Timeout counter:
  - Clears on every accepted byte and on entry to S_ADDR.
  - Counts in S_ADDR, S_DATA and S_CSUM.
  - When it reaches TIMEOUT_CYCLES-1 with no rx_valid, pulse err_timeout, discard partial bytes and go to S_CMD.
  - An rx_valid in that same cycle wins: the byte is accepted and there is no timeout.
- Reset (synchronous, at any point including mid-frame or in S_HOLD):
  - State goes to S_CMD.
  - frm_valid=0, busy=0, and all err_* outputs are 0.
  - frm_cmd, frm_addr and frm_data are all 0.
  - Counters and the checksum clear.

## Timing
- frm_valid and all frame and error outputs are registered.
- Latency: the final byte (checksum, or the last data byte) is strobed in cycle N.
  - frm_valid=1 in cycle N+1.
  - err_checksum pulses in cycle N+1 on a mismatch.
- Handshake: the transfer occurs in the cycle where frm_valid and frm_ready are both 1. frm_valid=0 in the next cycle unless reset intervenes.
- frm_ready has no effect while frm_valid=0.
- Maximum throughput: one byte per clk, back-to-back, with no loss, provided frm_ready is high when frm_valid is asserted.
- Error pulses are exactly one cycle wide and are mutually exclusive in any cycle.

## Test plan
- Defaults: bytes 0x02, 0x10, 0x34, 0x12, 0xA8 at arbitrary spacing, frm_ready=1 -> frm_valid for 1 cycle, one cycle after 0xA8, with frm_cmd=0x02, frm_addr=0x10, frm_data=0x1234. No error pulses.
- Same frame but checksum byte 0xA7 -> err_checksum one cycle after 0xA7, frm_valid never 1, and the next good frame is accepted normally.
- TIMEOUT_CYCLES=16: send 0x02, 0x10, then silence -> err_timeout 15 cycles after 0x10, busy=0 the next cycle. Then a full good frame decodes correctly.
- frm_ready held 0 after a good frame, then 2 further bytes -> frm_valid stays 1 with outputs unchanged, and err_overrun pulses twice. Raising frm_ready gives 1 transfer only.
- ADDR_BYTES=2, DATA_BYTES=4, CHECKSUM_EN=0, DATA_MSB_FIRST=1: bytes 0x05, 0xAB, 0xCD, 0x11, 0x22, 0x33, 0x44 -> frm_addr=0xABCD, frm_data=0x11223344.
- Reset asserted for 1 cycle after the 3rd byte of a frame -> all outputs 0 the next cycle. A fresh complete frame then decodes correctly and no stale bytes appear.
